// File: rtl/platform_field.sv
// platform_field: owns the jump-platform table for the game screen.
//
// Purpose
//   - Renders platforms per pixel (combinational, zero latency) for the painter.
//   - Scrolls every platform down once per frame; platforms leaving the bottom
//     respawn at the top with a pseudo-random x taken from a 16-bit LFSR.
//   - Reports (registered) whether the falling doodle's feet rest on a platform.
//
// Ports
//   clk            system clock
//   rst            asynchronous active-high reset
//   frame_start    one-cycle pulse at the start of vertical blanking
//   scroll_req     pixels to scroll this frame, sampled on frame_start
//   beam_x/beam_y  current beam position
//   doodle_x       doodle left edge
//   doodle_feet_y  doodle bottom row
//   doodle_falling doodle is moving downward
//   color          platform pixel colour, [0]=R [1]=G [2]=B
//   is_transparent no platform covers the beam
//   landed         doodle feet are on a platform (registered)
//   landed_y       top row of the platform landed on (registered)
//   busy           scroll update in progress
module platform_field #(
    parameter int unsigned NUM_PLATFORMS = 8,
    parameter int unsigned SPACING       = 90,
    parameter int unsigned PLAT_W        = 96,
    parameter int unsigned PLAT_H        = 16,
    parameter int unsigned DOODLE_W      = 64,
    parameter int unsigned SCREEN_W      = 1280,
    parameter int unsigned SCREEN_H      = 720,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_start,
    input  logic [5:0]       scroll_req,
    input  logic [10:0]      beam_x,
    input  logic [9:0]       beam_y,
    input  logic [10:0]      doodle_x,
    input  logic [9:0]       doodle_feet_y,
    input  logic             doodle_falling,
    output logic [2:0][3:0]  color,
    output logic             is_transparent,
    output logic             landed,
    output logic [9:0]       landed_y,
    output logic             busy
);

    localparam int unsigned XRange = SCREEN_W - PLAT_W;
    localparam int unsigned IdxW   = (NUM_PLATFORMS > 1) ? $clog2(NUM_PLATFORMS) : 1;

    // An all-zero seed would lock the LFSR up.
    localparam logic [15:0] SeedEff = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

    // Widened constants so compares never wrap near the screen edges.
    localparam logic [11:0] PlatW12   = 12'(PLAT_W);
    localparam logic [11:0] DoodleW12 = 12'(DOODLE_W);
    localparam logic [10:0] PlatH11   = 11'(PLAT_H);
    localparam logic [10:0] HalfH11   = 11'(PLAT_H / 2);
    localparam logic [10:0] ScreenH11 = 11'(SCREEN_H);
    localparam logic [10:0] XRange11  = 11'(XRange);
    localparam logic [10:0] TopRows11 = 11'd4;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_PLATFORMS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StScroll,
        StDone
    } state_e;

    function automatic logic [10:0] reset_x(input int i);
        return 11'((i * 384 + 100) % int'(XRange));
    endfunction

    function automatic logic [9:0] reset_y(input int i);
        return 10'(int'(SCREEN_H) - 40 - i * int'(SPACING));
    endfunction

    // Platform table
    logic [10:0] x_q [NUM_PLATFORMS];
    logic [9:0]  y_q [NUM_PLATFORMS];

    // FSM and scroll datapath
    state_e          state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [5:0]      scroll_amt_q, scroll_amt_d;
    logic [15:0]     lfsr_q;
    logic            upd_en;

    logic [9:0]  cur_y;
    logic [10:0] y_new;
    logic        respawn;
    logic [9:0]  y_wrap;
    logic [15:0] lfsr_next;
    logic [10:0] x_raw;
    logic [10:0] x_new;

    // Landing
    logic       landed_q, landed_d;
    logic [9:0] landed_y_q, landed_y_d;

    // Pixel path
    logic hit;
    logic top_hit;

    //--------------------------------------------------------------------------
    // Pixel path
    //--------------------------------------------------------------------------
    always_comb begin
        hit     = 1'b0;
        top_hit = 1'b0;
        for (int i = 0; i < int'(NUM_PLATFORMS); i++) begin
            if (({1'b0, beam_x} >= {1'b0, x_q[i]}) &&
                ({1'b0, beam_x} <  {1'b0, x_q[i]} + PlatW12) &&
                ({1'b0, beam_y} >= {1'b0, y_q[i]}) &&
                ({1'b0, beam_y} <  {1'b0, y_q[i]} + PlatH11)) begin
                hit = 1'b1;
                if ({1'b0, beam_y} < {1'b0, y_q[i]} + TopRows11) begin
                    top_hit = 1'b1;
                end
            end
        end
    end

    always_comb begin
        color = '0;
        if (top_hit) begin
            // Bright top edge of the platform
            color[0] = 4'h6;
            color[1] = 4'hD;
            color[2] = 4'h2;
        end else if (hit) begin
            color[0] = 4'h3;
            color[1] = 4'h9;
            color[2] = 4'h1;
        end
    end

    assign is_transparent = ~hit;

    //--------------------------------------------------------------------------
    // Landing detection
    //--------------------------------------------------------------------------
    always_comb begin
        landed_d   = 1'b0;
        landed_y_d = landed_y_q;
        // Descending scan so the lowest-index match is the one kept.
        for (int i = int'(NUM_PLATFORMS) - 1; i >= 0; i--) begin
            if (doodle_falling &&
                ({1'b0, doodle_feet_y} >= {1'b0, y_q[i]}) &&
                ({1'b0, doodle_feet_y} <  {1'b0, y_q[i]} + HalfH11) &&
                ({1'b0, doodle_x} + DoodleW12 > {1'b0, x_q[i]}) &&
                ({1'b0, doodle_x} < {1'b0, x_q[i]} + PlatW12)) begin
                landed_d   = 1'b1;
                landed_y_d = y_q[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            landed_q   <= 1'b0;
            landed_y_q <= '0;
        end else begin
            landed_q   <= landed_d;
            landed_y_q <= landed_y_d;
        end
    end

    assign landed   = landed_q;
    assign landed_y = landed_y_q;

    //--------------------------------------------------------------------------
    // Scroll FSM
    //--------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        scroll_amt_d = scroll_amt_q;
        upd_en       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (frame_start) begin
                    scroll_amt_d = scroll_req;
                    idx_d        = '0;
                    state_d      = StScroll;
                end
            end
            StScroll: begin
                upd_en = 1'b1;
                idx_d  = idx_q + 1'b1;
                if (idx_q == LastIdx) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            scroll_amt_q <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            scroll_amt_q <= scroll_amt_d;
        end
    end

    // busy covers the SCROLL cycles plus the DONE cycle.
    assign busy = (state_q != StIdle);

    //--------------------------------------------------------------------------
    // Per-slot update datapath
    //--------------------------------------------------------------------------
    always_comb begin
        cur_y     = y_q[idx_q];
        y_new     = {1'b0, cur_y} + {5'd0, scroll_amt_q};
        respawn   = (y_new >= ScreenH11);
        y_wrap    = respawn ? 10'(y_new - ScreenH11) : y_new[9:0];
        // Taps 16,14,13,11 -> bits 15,13,12,10; shift left, feedback into bit 0.
        lfsr_next = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        x_raw     = lfsr_next[10:0];
        // 11-bit max is below twice the range, so one subtract is enough.
        x_new     = (x_raw >= XRange11) ? (x_raw - XRange11) : x_raw;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= SeedEff;
            for (int i = 0; i < int'(NUM_PLATFORMS); i++) begin
                x_q[i] <= reset_x(i);
                y_q[i] <= reset_y(i);
            end
        end else if (upd_en) begin
            y_q[idx_q] <= y_wrap;
            if (respawn) begin
                x_q[idx_q] <= x_new;
                lfsr_q     <= lfsr_next;
            end
        end
    end

endmodule
